// File: rtl/nios_hs_pkg.sv
// Shared types and bit offsets for the Nios GPI/GPO handshake controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nios_hs_pkg;

  typedef enum logic {
    OP_PROC = 1'b0,
    OP_PING = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_NIOS_ERR = 2'd1,
    ST_TIMEOUT  = 2'd2,
    ST_BAD_CH   = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREQ,
    S_PWAIT,
    S_PCLR,
    S_GREQ,
    S_GCLR,
    S_RESP
  } state_e;

  // GPI (controller -> Nios) bit offsets inside one channel nibble
  localparam int GPI_PROC_REQ  = 0;
  localparam int GPI_CLR_STATE = 1;
  localparam int GPI_PING_REQ  = 2;
  localparam int GPI_CLR_PING  = 3;

  // GPO (Nios -> controller) bit offsets inside one channel nibble
  localparam int GPO_BUSY     = 0;
  localparam int GPO_DONE     = 1;
  localparam int GPO_ERR      = 2;
  localparam int GPO_PING_RSP = 3;

  // One-hot nibbles for the single GPI bit asserted in each request phase
  localparam logic [3:0] NIB_PROC_REQ  = 4'b0001;
  localparam logic [3:0] NIB_CLR_STATE = 4'b0010;
  localparam logic [3:0] NIB_PING_REQ  = 4'b0100;
  localparam logic [3:0] NIB_CLR_PING  = 4'b1000;

endpackage

// File: rtl/nios_gpo_sync.sv
// Register chain that brings the Nios GPO bits into the controller clock domain.
// Latency: STAGES cycles (combinational pass-through when STAGES = 0).
// Backpressure: none; samples every cycle.
module nios_gpo_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             sys_clk_main_fpga,
  input  logic             sys_reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, sys_clk_main_fpga, sys_reset};
    assign q = d;
  end else begin : g_chain
    logic [WIDTH-1:0] stg [STAGES];

    // Shift the GPO vector down the chain; reset flushes every stage
    always_ff @(posedge sys_clk_main_fpga) begin
      if (sys_reset) begin
        for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[STAGES-1];
  end

endmodule

// File: rtl/nios_hs_ctrl.sv
// Host command -> Nios GPI/GPO four-phase handshake controller, one transaction in flight.
// Latency: request bit one cycle after accept; every GPO-driven decision lags by SYNC_STAGES+1.
// Backpressure: cmd_ready only in idle; response held in RESP until rsp_ready.
module nios_hs_ctrl
  import nios_hs_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SYNC_STAGES    = 2,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  sys_clk_main_fpga,
  input  logic                  sys_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [CH_W-1:0]       cmd_ch,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [1:0]            rsp_status,
  output logic [CH_W-1:0]       rsp_ch,
  output logic [4*NUM_CH-1:0]   u_gpi,
  input  logic [4*NUM_CH-1:0]   u_gpo
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  state_e              state;
  logic [TO_W-1:0]     cnt;
  logic [CH_W-1:0]     ch_q;
  logic                err_q;
  logic [4*NUM_CH-1:0] gpo_s;
  logic [3:0]          ch_gpo;
  logic                waiting;
  logic                advance;
  logic                to_hit;

  // Place a 4-bit GPI nibble at the given channel, zeros elsewhere
  function automatic logic [4*NUM_CH-1:0] place(input logic [3:0] nib, input logic [CH_W-1:0] ch);
    place = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == CH_W'(c)) place[4*c +: 4] = nib;
    end
  endfunction

  nios_gpo_sync #(
    .WIDTH  (4*NUM_CH),
    .STAGES (SYNC_STAGES)
  ) u_gpo_sync (
    .sys_clk_main_fpga (sys_clk_main_fpga),
    .sys_reset         (sys_reset),
    .d                 (u_gpo),
    .q                 (gpo_s)
  );

  // Select the synced GPO nibble of the channel currently being served
  always_comb begin
    ch_gpo = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_q == CH_W'(c)) ch_gpo = gpo_s[4*c +: 4];
    end
  end

  // Exit condition of each wait phase; error wins in PWAIT via err_q capture
  always_comb begin
    advance = 1'b0;
    waiting = 1'b1;
    case (state)
      S_PREQ:  advance = ch_gpo[GPO_BUSY] | ch_gpo[GPO_DONE] | ch_gpo[GPO_ERR];
      S_PWAIT: advance = ch_gpo[GPO_DONE] | ch_gpo[GPO_ERR];
      S_PCLR:  advance = ~ch_gpo[GPO_DONE] & ~ch_gpo[GPO_ERR];
      S_GREQ:  advance = ch_gpo[GPO_PING_RSP];
      S_GCLR:  advance = ~ch_gpo[GPO_PING_RSP];
      default: waiting = 1'b0;
    endcase
  end

  assign to_hit = (cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Handshake FSM; counter restarts on every state change, outputs all registered
  always_ff @(posedge sys_clk_main_fpga) begin
    if (sys_reset) begin
      state      <= S_IDLE;
      u_gpi      <= '0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_ch     <= '0;
      cnt        <= '0;
      ch_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt <= '0;
      if (waiting && !advance) begin
        if (to_hit) begin
          u_gpi      <= '0;
          state      <= S_RESP;
          rsp_valid  <= 1'b1;
          rsp_status <= ST_TIMEOUT;
          rsp_ch     <= ch_q;
        end else begin
          cnt <= cnt + TO_W'(1);
        end
      end else begin
        case (state)
          S_IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              cmd_ready <= 1'b0;
              ch_q      <= cmd_ch;
              err_q     <= 1'b0;
              if (int'(cmd_ch) >= NUM_CH) begin
                state      <= S_RESP;
                rsp_valid  <= 1'b1;
                rsp_status <= ST_BAD_CH;
                rsp_ch     <= cmd_ch;
              end else if (cmd_op == OP_PING) begin
                state <= S_GREQ;
                u_gpi <= place(NIB_PING_REQ, cmd_ch);
              end else begin
                state <= S_PREQ;
                u_gpi <= place(NIB_PROC_REQ, cmd_ch);
              end
            end
          end
          S_PREQ: begin
            u_gpi <= '0;
            state <= S_PWAIT;
          end
          S_PWAIT: begin
            err_q <= ch_gpo[GPO_ERR];
            u_gpi <= place(NIB_CLR_STATE, ch_q);
            state <= S_PCLR;
          end
          S_PCLR: begin
            u_gpi      <= '0;
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= err_q ? ST_NIOS_ERR : ST_OK;
            rsp_ch     <= ch_q;
          end
          S_GREQ: begin
            u_gpi <= place(NIB_CLR_PING, ch_q);
            state <= S_GCLR;
          end
          S_GCLR: begin
            u_gpi      <= '0;
            state      <= S_RESP;
            rsp_valid  <= 1'b1;
            rsp_status <= ST_OK;
            rsp_ch     <= ch_q;
          end
          S_RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios_hs_ctrl.sv
// Randomized bench for nios_hs_ctrl with a behavioural Nios agent and response scoreboard.
// Latency: checks request/clear edge timing against SYNC_STAGES+1 and timeout lengths.
// Backpressure: rsp_ready randomly throttled, plus a forced 10-cycle stall.
module tb_nios_hs_ctrl;
  import nios_hs_pkg::*;

  localparam int NUM_CH         = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int SYNC_STAGES    = 2;
  localparam int CH_W           = 2;
  localparam int GW             = 4 * NUM_CH;

  localparam int M_NORMAL = 0;
  localparam int M_BOTH   = 1;
  localparam int M_ERR    = 2;
  localparam int M_FAST   = 3;
  localparam int M_SILENT = 4;
  localparam int M_STUCK  = 5;

  typedef struct packed {
    logic [1:0]      st;
    logic [CH_W-1:0] ch;
  } exp_t;

  logic            clk;
  logic            sys_reset;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_op;
  logic [CH_W-1:0] cmd_ch;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_status;
  logic [CH_W-1:0] rsp_ch;
  logic [GW-1:0]   u_gpi;
  logic [GW-1:0]   u_gpo;

  int       compared = 0;
  int       failed   = 0;
  exp_t     sb_q[$];
  logic [GW-1:0] act_mask = '0;
  logic     hold_rsp = 1'b0;

  nios_hs_ctrl #(
    .NUM_CH         (NUM_CH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .sys_clk_main_fpga (clk),
    .sys_reset         (sys_reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_op            (cmd_op),
    .cmd_ch            (cmd_ch),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_status        (rsp_status),
    .rsp_ch            (rsp_ch),
    .u_gpi             (u_gpi),
    .u_gpo             (u_gpo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outcome of a transaction from the command and the agent's behaviour
  function automatic logic [1:0] ref_status(input logic op, input int ch, input int mode);
    if (ch >= NUM_CH) return ST_BAD_CH;
    if (op == OP_PING) return (mode == M_SILENT) ? ST_TIMEOUT : ST_OK;
    if (mode == M_SILENT || mode == M_STUCK) return ST_TIMEOUT;
    if (mode == M_BOTH || mode == M_ERR) return ST_NIOS_ERR;
    return ST_OK;
  endfunction

  // Response driver: random throttling, forced low while hold_rsp is set
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop expected response on each handshake; check GPI isolation every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!sys_reset) begin
        if ((u_gpi & ~act_mask) != '0) check("gpi_isolation", u_gpi & ~act_mask, 0);
        if (rsp_valid && rsp_ready) begin
          check("rsp_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_status", rsp_status, e.st);
            check("rsp_ch", rsp_ch, e.ch);
          end
        end
      end
    end
  end

  task automatic wait_gpi(input int idx, input logic val, input string name, output int n);
    n = 0;
    while (u_gpi[idx] !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, u_gpi[idx], val);
  endtask

  // Present a command from a negedge; returns at the negedge after acceptance
  task automatic issue(input logic op, input int ch);
    int n;
    n = 0;
    cmd_op    = op;
    cmd_ch    = CH_W'(ch);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic proc_agent(input int ch, input int mode, input int d1, input int d2, input int d3);
    int base;
    int n;
    base = 4 * ch;
    check("proc_req_rise", u_gpi[base+GPI_PROC_REQ], 1);
    if (mode == M_SILENT) begin
      wait_gpi(base+GPI_PROC_REQ, 1'b0, "proc_req_timeout_fall", n);
      check("preq_timeout_len", n, TIMEOUT_CYCLES);
      return;
    end
    repeat (d1) @(negedge clk);
    if (mode == M_FAST) u_gpo[base+GPO_DONE] = 1'b1;
    else                u_gpo[base+GPO_BUSY] = 1'b1;
    wait_gpi(base+GPI_PROC_REQ, 1'b0, "proc_req_fall", n);
    check("proc_req_fall_lat", n, SYNC_STAGES + 1);
    if (mode == M_FAST) begin
      wait_gpi(base+GPI_CLR_STATE, 1'b1, "clr_state_rise", n);
    end else begin
      repeat (d2) @(negedge clk);
      u_gpo[base+GPO_BUSY] = 1'b0;
      u_gpo[base+GPO_DONE] = (mode != M_ERR);
      u_gpo[base+GPO_ERR]  = (mode == M_BOTH || mode == M_ERR || mode == M_STUCK);
      wait_gpi(base+GPI_CLR_STATE, 1'b1, "clr_state_rise", n);
      check("clr_state_rise_lat", n, SYNC_STAGES + 1);
    end
    if (mode == M_STUCK) begin
      wait_gpi(base+GPI_CLR_STATE, 1'b0, "clr_state_timeout_fall", n);
      check("pclr_timeout_len", n, TIMEOUT_CYCLES);
      u_gpo[base +: 4] = 4'b0000;
      return;
    end
    repeat (d3) @(negedge clk);
    u_gpo[base +: 4] = 4'b0000;
    wait_gpi(base+GPI_CLR_STATE, 1'b0, "clr_state_fall", n);
    check("clr_state_fall_lat", n, SYNC_STAGES + 1);
  endtask

  task automatic ping_agent(input int ch, input int mode, input int d1, input int d3);
    int base;
    int n;
    base = 4 * ch;
    check("ping_req_rise", u_gpi[base+GPI_PING_REQ], 1);
    if (mode == M_SILENT) begin
      wait_gpi(base+GPI_PING_REQ, 1'b0, "ping_req_timeout_fall", n);
      check("greq_timeout_len", n, TIMEOUT_CYCLES);
      return;
    end
    repeat (d1) @(negedge clk);
    u_gpo[base+GPO_PING_RSP] = 1'b1;
    wait_gpi(base+GPI_CLR_PING, 1'b1, "clr_ping_rise", n);
    check("clr_ping_rise_lat", n, SYNC_STAGES + 1);
    check("ping_req_dropped", u_gpi[base+GPI_PING_REQ], 0);
    repeat (d3) @(negedge clk);
    u_gpo[base+GPO_PING_RSP] = 1'b0;
    wait_gpi(base+GPI_CLR_PING, 1'b0, "clr_ping_fall", n);
    check("clr_ping_fall_lat", n, SYNC_STAGES + 1);
  endtask

  task automatic run_txn(input logic op, input int ch, input int mode, input int d1, input int d2, input int d3);
    exp_t e;
    e.st = ref_status(op, ch, mode);
    e.ch = CH_W'(ch);
    sb_q.push_back(e);
    act_mask = (ch < NUM_CH) ? (GW'(4'hF) << (4 * ch)) : '0;
    issue(op, ch);
    if (ch >= NUM_CH) begin
      check("badch_rsp_valid", rsp_valid, 1);
      check("badch_gpi_zero", u_gpi, 0);
    end else if (op == OP_PROC) begin
      proc_agent(ch, mode, d1, d2, d3);
    end else begin
      ping_agent(ch, mode, d1, d3);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int r;
    int mode;
    sys_reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_ch    = '0;
    u_gpo     = '0;

    repeat (3) @(negedge clk);
    check("rst_u_gpi", u_gpi, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_status", rsp_status, 0);
    check("rst_rsp_ch", rsp_ch, 0);
    sys_reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Directed scenarios
    run_txn(OP_PROC, 1, M_NORMAL, 1, 5, 2);
    run_txn(OP_PROC, 0, M_BOTH,   0, 2, 1);
    run_txn(OP_PING, 0, M_SILENT, 0, 0, 0);
    run_txn(OP_PROC, 3, M_NORMAL, 0, 0, 0);
    run_txn(OP_PROC, 2, M_STUCK,  2, 1, 0);
    run_txn(OP_PING, 2, M_NORMAL, 3, 0, 2);
    run_txn(OP_PROC, 1, M_ERR,    0, 0, 0);
    run_txn(OP_PROC, 0, M_FAST,   1, 0, 1);

    // Reset while waiting for done: no response, GPI cleared, ready after release
    act_mask = GW'(4'hF) << 4;
    issue(OP_PROC, 1);
    check("rst_txn_req_rise", u_gpi[4+GPI_PROC_REQ], 1);
    u_gpo[4+GPO_BUSY] = 1'b1;
    wait_gpi(4+GPI_PROC_REQ, 1'b0, "rst_txn_req_fall", n);
    repeat (2) @(negedge clk);
    sys_reset = 1'b1;
    @(negedge clk);
    check("midrst_u_gpi", u_gpi, 0);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    sys_reset = 1'b0;
    u_gpo = '0;
    @(negedge clk);
    check("midrst_release_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);

    // Response stall: fields stable and no command accepted for 10 cycles
    hold_rsp = 1'b1;
    @(negedge clk);
    sb_q.push_back('{st: ST_BAD_CH, ch: CH_W'(3)});
    act_mask = '0;
    issue(OP_PING, 3);
    for (int i = 0; i < 10; i++) begin
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_rsp_status", rsp_status, ST_BAD_CH);
      check("stall_rsp_ch", rsp_ch, 3);
      check("stall_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    hold_rsp = 1'b0;
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      r    = $urandom_range(0, 7);
      mode = (r <= 2) ? M_NORMAL : (r - 2);
      run_txn(logic'($urandom_range(0, 1)), $urandom_range(0, 3), mode,
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4));
    end

    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/nios_hs_ctrl.md
NIOS_HS_CTRL -- requirements
Module: nios_hs_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, range 1..8: Nios channels, each with 4 GPI and 4 GPO bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, range 4..2^20: per-phase wait limit.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, range 0..3: GPO input register stages.
REQ-004 SHALL define CH_W = max(1, clog2(NUM_CH)).
REQ-005 SHALL have port sys_clk_main_fpga, input, 1: sole clock. One clock; reset is synchronous and active-high.
REQ-006 SHALL have port sys_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port cmd_valid, input, 1: host command valid.
REQ-008 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-009 SHALL have port cmd_op, input, 1: 0 = PROC (data-process), 1 = PING.
REQ-010 SHALL have port cmd_ch, input, CH_W: target channel.
REQ-011 SHALL have port rsp_valid, output, 1: response valid.
REQ-012 SHALL have port rsp_ready, input, 1: host accepts response.
REQ-013 SHALL have port rsp_status, output, 2: 0 OK, 1 NIOS_ERR, 2 TIMEOUT, 3 BAD_CH.
REQ-014 SHALL have port rsp_ch, output, CH_W: channel of the response.
REQ-015 SHALL have port u_gpi, output, 4*NUM_CH: per channel c, bit 4c+0 proc_request, +1 clear_state, +2 ping_request, +3 clear_ping.
REQ-016 SHALL have port u_gpo, input, 4*NUM_CH: per channel c, bit 4c+0 busy, +1 done, +2 error, +3 ping_response.

Function
REQ-017 SHALL use FSM states IDLE, PREQ, PWAIT, PCLR, GREQ, GCLR, RESP; one transaction in flight at a time.
REQ-018 SHALL drive cmd_ready high only in IDLE with rsp_valid low.
REQ-019 On accept, SHALL latch op and channel, and enter PREQ (PROC) or GREQ (PING); if cmd_ch >= NUM_CH, SHALL enter RESP with BAD_CH and leave u_gpi unchanged.
REQ-020 All u_gpi bits SHALL be registered; the request bit rises on the cycle after accept.
REQ-021 PREQ: SHALL hold proc_request high until synced busy, done or error is seen, then go to PWAIT with proc_request low.
REQ-022 PWAIT: SHALL wait for done or error; if both are high in the same cycle, error SHALL win (NIOS_ERR); otherwise status is OK.
REQ-023 PCLR: SHALL hold clear_state high until done and error are both low, then go to RESP.
REQ-024 GREQ: SHALL hold ping_request high until ping_response is high. GCLR: SHALL hold clear_ping high until ping_response is low, then go to RESP with OK.
REQ-025 SHALL clear the timeout counter on every state entry and increment it each cycle in PREQ, PWAIT, PCLR, GREQ and GCLR.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1, SHALL drop that channel's GPI bits on the next cycle and enter RESP with TIMEOUT.
REQ-027 A timeout in PCLR SHALL override a previously latched NIOS_ERR.
REQ-028 RESP: SHALL hold rsp_valid, rsp_status and rsp_ch stable until rsp_ready, then return to IDLE. SHALL NOT accept a new command in the same cycle.
REQ-029 Only the latched channel's GPI bits SHALL ever be high; all other GPI bits are 0.
REQ-030 GPO SHALL pass through SYNC_STAGES register stages, adding SYNC_STAGES cycles of latency to every wait decision.

Reset
REQ-031 While sys_reset is high, SHALL set: FSM IDLE, u_gpi all 0, cmd_ready 0, rsp_valid 0, rsp_status 0, rsp_ch 0, timeout counter 0, sync stages 0.
REQ-032 Reset mid-transaction SHALL abort it with no response; cmd_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-033 Package nios_hs_pkg SHALL hold the op enum, status enum, FSM state enum and the GPI/GPO bit-offset constants.
REQ-034 Sub-module nios_gpo_sync SHALL implement the SYNC_STAGES register chain, 4*NUM_CH bits wide, with a pass-through when SYNC_STAGES = 0.

Verification
REQ-035 NUM_CH=2, PROC on ch1; model raises busy, then done at +5 -> u_gpi[4] high until busy; clear_state (u_gpi[5]) high until done low; rsp OK, ch1.
REQ-036 PROC on ch0; model raises done and error in the same cycle -> rsp_status NIOS_ERR.
REQ-037 TIMEOUT_CYCLES=16, PING on ch0; model never responds -> u_gpi[2] low 16 cycles after rising; rsp TIMEOUT.
REQ-038 NUM_CH=3, cmd_ch=3 -> rsp BAD_CH one cycle after accept; u_gpi stays 0.
REQ-039 sys_reset pulsed during PWAIT -> u_gpi=0 and rsp_valid=0 next cycle; cmd_ready=1 after release.
REQ-040 rsp_ready held low 10 cycles -> rsp fields stable; cmd_ready low throughout.
